ibis_raster_walker: RTL and testbench

//  Triangle bounding-box walker feeding the edge-finder stage. Accepts one

---
 rtl/ibis_raster_walker.sv | 159 +++++++++++++++
 tb/tb_ibis_raster_walker.sv | 136 +++++++++++++
 2 files changed

// File: rtl/ibis_raster_walker.sv
// Triangle bounding-box walker: clamps the vertex bounding box to the screen
// and streams every pixel inside it in raster order over valid/ready.
module ibis_raster_walker #(
  parameter int WIDTH = 11,
  parameter int MAX_X = 639,
  parameter int MAX_Y = 479
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             tri_valid,
  output logic             tri_ready,
  input  logic [WIDTH-1:0] a_x,
  input  logic [WIDTH-1:0] a_y,
  input  logic [WIDTH-1:0] b_x,
  input  logic [WIDTH-1:0] b_y,
  input  logic [WIDTH-1:0] c_x,
  input  logic [WIDTH-1:0] c_y,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [WIDTH-1:0] pix_x,
  output logic [WIDTH-1:0] pix_y,
  output logic             pix_first,
  output logic             pix_last,
  output logic             busy
);

  localparam logic [WIDTH-1:0] LIM_X = WIDTH'(MAX_X);
  localparam logic [WIDTH-1:0] LIM_Y = WIDTH'(MAX_Y);
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO  = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BOUND = 2'd1,
    WALK  = 2'd2
  } state_t;

  state_t state;

  logic [WIDTH-1:0] ax, ay, bx, by, cx, cy;
  logic [WIDTH-1:0] min_x, max_x, min_y, max_y;
  logic [WIDTH-1:0] bmin_x, bmax_x, bmin_y, bmax_y;
  logic [WIDTH-1:0] raw_max_x, raw_max_y;
  logic             box_empty;
  logic [WIDTH-1:0] nx, ny;
  logic             at_end;

  function automatic logic [WIDTH-1:0] min3(input logic [WIDTH-1:0] p,
                                            input logic [WIDTH-1:0] q,
                                            input logic [WIDTH-1:0] r);
    logic [WIDTH-1:0] m;
    m = (p < q) ? p : q;
    return (r < m) ? r : m;
  endfunction

  function automatic logic [WIDTH-1:0] max3(input logic [WIDTH-1:0] p,
                                            input logic [WIDTH-1:0] q,
                                            input logic [WIDTH-1:0] r);
    logic [WIDTH-1:0] m;
    m = (p > q) ? p : q;
    return (r > m) ? r : m;
  endfunction

  // Screen-clamped bounding box of the latched vertices.
  always_comb begin
    bmin_x    = min3(ax, bx, cx);
    bmin_y    = min3(ay, by, cy);
    raw_max_x = max3(ax, bx, cx);
    raw_max_y = max3(ay, by, cy);
    bmax_x    = (raw_max_x > LIM_X) ? LIM_X : raw_max_x;
    bmax_y    = (raw_max_y > LIM_Y) ? LIM_Y : raw_max_y;
    box_empty = (bmin_x > LIM_X) || (bmin_y > LIM_Y);
  end

  // Next cursor position in raster order; at_end marks the final pixel.
  always_comb begin
    nx     = pix_x;
    ny     = pix_y;
    at_end = 1'b0;
    if (pix_x != max_x) begin
      nx = pix_x + ONE;
    end else if (pix_y != max_y) begin
      nx = min_x;
      ny = pix_y + ONE;
    end else begin
      at_end = 1'b1;
    end
  end

  // Control FSM with all stream outputs registered.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state     <= IDLE;
      tri_ready <= 1'b1;
      pix_valid <= 1'b0;
      pix_x     <= ZERO;
      pix_y     <= ZERO;
      pix_first <= 1'b0;
      pix_last  <= 1'b0;
      busy      <= 1'b0;
      ax <= ZERO; ay <= ZERO; bx <= ZERO; by <= ZERO; cx <= ZERO; cy <= ZERO;
      min_x <= ZERO; max_x <= ZERO; min_y <= ZERO; max_y <= ZERO;
    end else begin
      case (state)
        IDLE: begin
          if (tri_valid && tri_ready) begin
            ax <= a_x; ay <= a_y;
            bx <= b_x; by <= b_y;
            cx <= c_x; cy <= c_y;
            tri_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= BOUND;
          end
        end
        BOUND: begin
          if (box_empty) begin
            tri_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            min_x     <= bmin_x;
            max_x     <= bmax_x;
            min_y     <= bmin_y;
            max_y     <= bmax_y;
            pix_x     <= bmin_x;
            pix_y     <= bmin_y;
            pix_first <= 1'b1;
            pix_last  <= (bmin_x == bmax_x) && (bmin_y == bmax_y);
            pix_valid <= 1'b1;
            state     <= WALK;
          end
        end
        WALK: begin
          if (pix_ready) begin
            pix_first <= 1'b0;
            if (at_end) begin
              pix_valid <= 1'b0;
              pix_last  <= 1'b0;
              tri_ready <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              pix_x    <= nx;
              pix_y    <= ny;
              pix_last <= (nx == max_x) && (ny == max_y);
            end
          end
        end
        default: begin
          state     <= IDLE;
          tri_ready <= 1'b1;
          pix_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ibis_raster_walker.sv
// Directed bench for ibis_raster_walker: hand-derived pixel sequences,
// stalls, screen clamping, empty boxes, degenerate input and mid-walk reset.
module tb_ibis_raster_walker;
  localparam int WIDTH = 11;

  logic             aclk = 1'b0;
  logic             areset = 1'b1;
  logic             tri_valid = 1'b0;
  logic             tri_ready;
  logic [WIDTH-1:0] a_x = '0, a_y = '0, b_x = '0, b_y = '0, c_x = '0, c_y = '0;
  logic             pix_valid;
  logic             pix_ready = 1'b0;
  logic [WIDTH-1:0] pix_x, pix_y;
  logic             pix_first, pix_last, busy;

  int checks = 0;
  int passes = 0;

  ibis_raster_walker #(.WIDTH(WIDTH), .MAX_X(639), .MAX_Y(479)) dut (
    .aclk(aclk), .areset(areset),
    .tri_valid(tri_valid), .tri_ready(tri_ready),
    .a_x(a_x), .a_y(a_y), .b_x(b_x), .b_y(b_y), .c_x(c_x), .c_y(c_y),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_first(pix_first), .pix_last(pix_last),
    .busy(busy)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Present a triangle for one cycle; returns at the negedge after the accept.
  task automatic send_tri(input int ax_i, input int ay_i, input int bx_i,
                          input int by_i, input int cx_i, input int cy_i);
    @(negedge aclk);
    check("tri_ready_idle", {31'd0, tri_ready}, 32'd1);
    a_x = WIDTH'(ax_i); a_y = WIDTH'(ay_i);
    b_x = WIDTH'(bx_i); b_y = WIDTH'(by_i);
    c_x = WIDTH'(cx_i); c_y = WIDTH'(cy_i);
    tri_valid = 1'b1;
    @(negedge aclk);
    tri_valid = 1'b0;
    check("bound_state", {29'd0, tri_ready, busy, pix_valid}, 32'b010);
  endtask

  // Walk the box [x0..x1]x[y0..y1], accepting stop_after pixels.
  task automatic walk(input int x0, input int x1, input int y0, input int y1,
                      input bit toggle, input int stop_after, input bit expect_done);
    int w, n, idx, cyc, budget, ex, ey;
    logic [31:0] expv;
    bit rdy;
    w = x1 - x0 + 1;
    n = w * (y1 - y0 + 1);
    idx = 0; cyc = 0; rdy = 1'b0;
    budget = stop_after * 3 + 10;
    while (idx < stop_after && cyc < budget) begin
      @(negedge aclk);
      cyc++;
      rdy = toggle ? ~rdy : 1'b1;
      pix_ready = rdy;
      if (cyc == 1) check("latency", {31'd0, pix_valid}, 32'd1);
      if (pix_valid) begin
        ex = x0 + idx % w;
        ey = y0 + idx / w;
        expv = 32'((ex << 13) | (ey << 2) | ((idx == 0 ? 1 : 0) << 1) | (idx == n - 1 ? 1 : 0));
        check("pixel", {8'd0, pix_x, pix_y, pix_first, pix_last}, expv);
        check("tri_ready_walk", {30'd0, tri_ready, busy}, 32'b01);
        if (rdy) idx++;
      end else if (idx > 0) begin
        check("valid_drop", {31'd0, pix_valid}, 32'd1);
      end
    end
    if (idx < stop_after) check("walk_timeout", 32'(idx), 32'(stop_after));
    if (expect_done) begin
      @(negedge aclk);
      pix_ready = 1'b0;
      check("walk_done", {29'd0, pix_valid, tri_ready, busy}, 32'b010);
    end
  endtask

  initial begin
    @(negedge aclk);
    check("reset_state", {8'd0, pix_x, pix_y, pix_valid, tri_ready}, 32'b01);
    check("reset_flags", {29'd0, pix_first, pix_last, busy}, 32'd0);
    @(negedge aclk);
    areset = 1'b0;

    // 1) basic 3x3 box, full throughput
    send_tri(2, 3, 4, 3, 3, 5);
    walk(2, 4, 3, 5, 1'b0, 9, 1'b1);

    // 2) same box with ready toggling
    send_tri(2, 3, 4, 3, 3, 5);
    walk(2, 4, 3, 5, 1'b1, 9, 1'b1);

    // 3) clamped at the bottom-right corner
    send_tri(630, 470, 700, 470, 630, 500);
    walk(630, 639, 470, 479, 1'b0, 100, 1'b1);

    // 4) entirely off-screen to the right
    send_tri(640, 10, 650, 20, 700, 30);
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      check("empty_box", {29'd0, pix_valid, tri_ready, busy}, 32'b010);
    end

    // 5) single degenerate pixel
    send_tri(7, 7, 7, 7, 7, 7);
    walk(7, 7, 7, 7, 1'b0, 1, 1'b1);

    // 6) reset mid-walk, then a fresh triangle
    send_tri(2, 3, 4, 3, 3, 5);
    walk(2, 4, 3, 5, 1'b0, 4, 1'b0);
    #2 areset = 1'b1;
    #1 check("reset_mid_walk", {29'd0, pix_valid, tri_ready, busy}, 32'b010);
    check("reset_mid_xy", {10'd0, pix_x, pix_y}, 32'd0);
    @(negedge aclk);
    areset = 1'b0;
    pix_ready = 1'b0;
    send_tri(10, 20, 12, 21, 11, 20);
    walk(10, 12, 20, 21, 1'b0, 6, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "global timeout");
  end
endmodule
